// File: rtl/tt_harness_seq_if.sv
// Load/capture stream bundle between a bench and the harness sequencer.
// Latency: wires only, no storage.
// Backpressure: ld_valid/ld_ready and cap_valid/cap_ready handshakes; transfer when both high.
interface tt_harness_seq_if #(
    parameter int HW = 4,
    parameter int CW = 20
) ();
    logic          ld_valid;
    logic          ld_ready;
    logic [HW+15:0] ld_data;
    logic          cap_valid;
    logic          cap_ready;
    logic [CW-1:0] cap_data;
    logic          cap_ovf;

    // Bench side: produces stimulus entries, consumes captures.
    modport master (
        output ld_valid, ld_data, cap_ready,
        input  ld_ready, cap_valid, cap_data, cap_ovf
    );

    // Harness side: accepts stimulus entries, produces captures.
    modport slave (
        input  ld_valid, ld_data, cap_ready,
        output ld_ready, cap_valid, cap_data, cap_ovf
    );
endinterface

// File: rtl/tt_harness_seq.sv
// Generic synchronous FIFO with flush; a pop frees space for a push in the same cycle.
// Latency: pushed word visible on pop_dat the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module tt_harness_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// TinyTapeout pad sequencer: resets/enables the DUT, replays a stimulus table, timestamps uo_out changes.
// Latency: RESET one cycle after start, RST_CYCLES reset cycles, then table replay, TAIL drain cycles.
// Backpressure: ld_ready only in IDLE with free table space; captures dropped (cap_ovf) when FIFO full.
module tt_harness_seq #(
    parameter int RST_CYCLES = 8,
    parameter int ENA_LEAD   = 2,
    parameter int DEPTH      = 16,
    parameter int HW         = 4,
    parameter int TAIL       = 4,
    parameter int CAP_DEPTH  = 16,
    parameter int TSW        = 12,
    parameter int CAP_UIO    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    tt_harness_seq_if.slave    bus,
    output logic               dut_rst_n,
    output logic               dut_ena,
    output logic [7:0]         dut_ui_in,
    output logic [7:0]         dut_uio_in,
    input  logic [7:0]         dut_uo_out,
    input  logic [7:0]         dut_uio_out,
    input  logic [7:0]         dut_uio_oe,
    output logic               busy,
    output logic               done
);
    localparam int SW   = 8 + 8 * CAP_UIO;
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state, state_n;
    logic [AW:0]     count, count_n;
    logic [AW-1:0]   idx, idx_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [HW+15:0]  tbl [DEPTH];
    logic [HW-1:0]   cur_hold;
    logic [15:0]     nxt_pad;
    logic            ld_fire;

    logic [SW-1:0]   sample, prev;
    logic [TSW-1:0]  ts;
    logic            first, cap_on, cap_push, cap_pop, fifo_full, fifo_empty;

    assign bus.ld_ready = rst_n && !abort && (state == S_IDLE) && (count < (AW+1)'(DEPTH));
    assign ld_fire      = bus.ld_valid && bus.ld_ready;
    assign cur_hold     = tbl[idx][HW+15:16];
    assign nxt_pad      = tbl[idx_n][15:0];
    assign busy         = (state == S_RESET) || (state == S_RUN) || (state == S_DRAIN);
    assign done         = (state == S_DONE);

    // Sequencer next-state: abort wins over everything; cnt is reused as reset, hold and tail counter.
    always_comb begin
        state_n = state;
        count_n = count;
        idx_n   = idx;
        cnt_n   = cnt;
        if (abort) begin
            state_n = S_IDLE;
            count_n = '0;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ld_fire) count_n = count + 1'b1;
                    if (start && count != '0) begin
                        state_n = S_RESET;
                        cnt_n   = '0;
                    end
                end
                S_RESET: begin
                    if (cnt == CNTW'(RST_CYCLES - 1)) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt == CNTW'(cur_hold)) begin
                        cnt_n = '0;
                        if ({1'b0, idx} == count - 1'b1) state_n = (TAIL == 0) ? S_DONE : S_DRAIN;
                        else                             idx_n   = idx + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CNTW'(TAIL - 1)) state_n = S_DONE;
                    else                        cnt_n   = cnt + 1'b1;
                end
                S_DONE: begin
                    if (start) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // Stimulus table write; ld_fire already excludes reset and abort.
    always_ff @(posedge clk) begin
        if (ld_fire) tbl[count[AW-1:0]] <= bus.ld_data;
    end

    // Pad registers driven from next state so every pad lines up with its state cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dut_rst_n  <= 1'b0;
            dut_ena    <= 1'b0;
            dut_ui_in  <= '0;
            dut_uio_in <= '0;
        end else begin
            dut_rst_n <= (state_n == S_RUN) || (state_n == S_DRAIN) || (state_n == S_DONE);
            dut_ena   <= (state_n == S_RUN) || (state_n == S_DRAIN) ||
                         ((state_n == S_RESET) && (cnt_n >= CNTW'(RST_CYCLES - ENA_LEAD)));
            if (state_n == S_RUN) begin
                dut_ui_in  <= nxt_pad[7:0];
                dut_uio_in <= nxt_pad[15:8];
            end else if (state_n != S_DRAIN) begin
                dut_ui_in  <= '0;
                dut_uio_in <= '0;
            end
        end
    end

    generate
        if (CAP_UIO != 0) begin : g_uio
            assign sample = {dut_uio_out & dut_uio_oe, dut_uo_out};
        end else begin : g_uo
            logic sig_unused;
            assign sample     = dut_uo_out;
            assign sig_unused = ^{dut_uio_out, dut_uio_oe};
        end
    endgenerate

    assign cap_on   = (state == S_RUN) || (state == S_DRAIN);
    assign cap_push = cap_on && (first || sample != prev);
    assign cap_pop  = bus.cap_valid && bus.cap_ready;

    // Timestamp restarts on entry to RUN and saturates; prev tracks the last captured-window sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts    <= '0;
            first <= 1'b0;
            prev  <= '0;
        end else begin
            if (state == S_RESET && state_n == S_RUN) begin
                ts    <= '0;
                first <= 1'b1;
            end else begin
                first <= 1'b0;
                if (cap_on && ts != '1) ts <= ts + 1'b1;
            end
            if (cap_on) prev <= sample;
        end
    end

    // Sticky overflow: a push was lost because the FIFO was full with no pop.
    always_ff @(posedge clk) begin
        if (!rst_n || abort)                       bus.cap_ovf <= 1'b0;
        else if (cap_push && fifo_full && !cap_pop) bus.cap_ovf <= 1'b1;
    end

    tt_harness_fifo #(.W(TSW + SW), .DEPTH(CAP_DEPTH)) u_cap_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push     (cap_push),
        .push_dat ({ts, sample}),
        .pop      (cap_pop),
        .pop_dat  (bus.cap_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.cap_valid = !fifo_empty;
endmodule

// File: tb/tb_tt_harness_seq.sv
// Directed bench for tt_harness_seq with a loopback DUT (uo_out = ui_in).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises full capture FIFO and full stimulus table.
module tb_tt_harness_seq;
    localparam int HW  = 4;
    localparam int TSW = 12;
    localparam int CW  = TSW + 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dut_rst_n, dut_ena, busy, done;
    logic [7:0] dut_ui_in, dut_uio_in, dut_uo_out, dut_uio_out, dut_uio_oe;
    int         checks = 0;
    int         passed = 0;

    tt_harness_seq_if #(.HW(HW), .CW(CW)) bus ();

    assign dut_uo_out  = dut_ui_in;
    assign dut_uio_out = dut_uio_in;
    assign dut_uio_oe  = 8'h00;

    tt_harness_seq #(
        .RST_CYCLES(8), .ENA_LEAD(2), .DEPTH(16), .HW(HW), .TAIL(4),
        .CAP_DEPTH(4), .TSW(TSW), .CAP_UIO(0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .bus         (bus),
        .dut_rst_n   (dut_rst_n),
        .dut_ena     (dut_ena),
        .dut_ui_in   (dut_ui_in),
        .dut_uio_in  (dut_uio_in),
        .dut_uo_out  (dut_uo_out),
        .dut_uio_out (dut_uio_out),
        .dut_uio_oe  (dut_uio_oe),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input logic [HW+15:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (dut_rst_n !== 1'b0) $display("FAIL reset_dut_rst_n got %b exp 0", dut_rst_n); else passed++;
        checks++; if (dut_ena !== 1'b0) $display("FAIL reset_dut_ena got %b exp 0", dut_ena); else passed++;
        checks++; if (dut_ui_in !== 8'h00) $display("FAIL reset_ui got %h exp 00", dut_ui_in); else passed++;
        checks++; if (dut_uio_in !== 8'h00) $display("FAIL reset_uio got %h exp 00", dut_uio_in); else passed++;
        checks++; if (bus.ld_ready !== 1'b0) $display("FAIL reset_ld_ready got %b exp 0", bus.ld_ready); else passed++;
        checks++; if (bus.cap_valid !== 1'b0) $display("FAIL reset_cap_valid got %b exp 0", bus.cap_valid); else passed++;
        checks++; if (bus.cap_ovf !== 1'b0) $display("FAIL reset_cap_ovf got %b exp 0", bus.cap_ovf); else passed++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b exp 00", busy, done); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if (bus.ld_ready !== 1'b1) $display("FAIL idle_ld_ready got %b exp 1", bus.ld_ready); else passed++;
    endtask

    task automatic test_start_empty();
        pulse_start();
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL start_empty_busy got %b exp 0", busy); else passed++;
        checks++; if (dut_rst_n !== 1'b0) $display("FAIL start_empty_rst got %b exp 0", dut_rst_n); else passed++;
    endtask

    task automatic test_sequence();
        logic [7:0]    eui, euio;
        logic [CW-1:0] ecap [3];
        load_entry({4'd0, 8'h00, 8'h01});
        load_entry({4'd2, 8'h00, 8'h02});
        load_entry({4'd0, 8'hFF, 8'h03});
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            checks++; if (dut_rst_n !== 1'b0) $display("FAIL rst_low_c%0d got %b exp 0", k, dut_rst_n); else passed++;
            checks++; if (dut_ena !== (k >= 7)) $display("FAIL ena_c%0d got %b exp %b", k, dut_ena, (k >= 7)); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL busy_reset_c%0d got %b exp 1", k, busy); else passed++;
            tick();
        end
        for (int r = 0; r < 9; r++) begin
            eui  = (r == 0) ? 8'h01 : (r < 4) ? 8'h02 : 8'h03;
            euio = (r >= 4) ? 8'hFF : 8'h00;
            checks++; if (dut_rst_n !== 1'b1) $display("FAIL run_rst_r%0d got %b exp 1", r, dut_rst_n); else passed++;
            checks++; if (dut_ena !== 1'b1) $display("FAIL run_ena_r%0d got %b exp 1", r, dut_ena); else passed++;
            checks++; if (dut_ui_in !== eui) $display("FAIL run_ui_r%0d got %h exp %h", r, dut_ui_in, eui); else passed++;
            checks++; if (dut_uio_in !== euio) $display("FAIL run_uio_r%0d got %h exp %h", r, dut_uio_in, euio); else passed++;
            checks++; if (done !== 1'b0) $display("FAIL run_done_r%0d got %b exp 0", r, done); else passed++;
            tick();
        end
        checks++; if (done !== 1'b1) $display("FAIL seq_done got %b exp 1", done); else passed++;
        checks++; if (dut_ena !== 1'b0) $display("FAIL done_ena got %b exp 0", dut_ena); else passed++;
        checks++; if (dut_rst_n !== 1'b1) $display("FAIL done_rst got %b exp 1", dut_rst_n); else passed++;
        checks++; if (dut_ui_in !== 8'h00 || dut_uio_in !== 8'h00) $display("FAIL done_pads got %h %h exp 00 00", dut_ui_in, dut_uio_in); else passed++;
        checks++; if (bus.cap_ovf !== 1'b0) $display("FAIL seq_ovf got %b exp 0", bus.cap_ovf); else passed++;
        ecap[0] = {12'd0, 8'h01};
        ecap[1] = {12'd1, 8'h02};
        ecap[2] = {12'd4, 8'h03};
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.cap_valid !== 1'b1) $display("FAIL seq_cap_valid%0d got %b exp 1", i, bus.cap_valid); else passed++;
            checks++; if (bus.cap_data !== ecap[i]) $display("FAIL seq_cap_data%0d got %h exp %h", i, bus.cap_data, ecap[i]); else passed++;
            bus.cap_ready = 1'b1;
            tick();
            bus.cap_ready = 1'b0;
        end
        checks++; if (bus.cap_valid !== 1'b0) $display("FAIL seq_cap_empty got %b exp 0", bus.cap_valid); else passed++;
    endtask

    task automatic test_abort();
        pulse_start();
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL done_to_idle got %b%b exp 00", busy, done); else passed++;
        pulse_start();
        checks++; if (busy !== 1'b1) $display("FAIL restart_kept_table got %b exp 1", busy); else passed++;
        repeat (9) tick();
        checks++; if (dut_ui_in !== 8'h02) $display("FAIL abort_pre_ui got %h exp 02", dut_ui_in); else passed++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle got %b%b exp 00", busy, done); else passed++;
        checks++; if (dut_rst_n !== 1'b0 || dut_ena !== 1'b0) $display("FAIL abort_rst_ena got %b%b exp 00", dut_rst_n, dut_ena); else passed++;
        checks++; if (dut_ui_in !== 8'h00) $display("FAIL abort_ui got %h exp 00", dut_ui_in); else passed++;
        checks++; if (bus.cap_valid !== 1'b0) $display("FAIL abort_cap_valid got %b exp 0", bus.cap_valid); else passed++;
        pulse_start();
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL abort_start_ignored got %b exp 0", busy); else passed++;
    endtask

    task automatic test_overflow();
        int            n;
        logic [CW-1:0] exp_d;
        for (int i = 0; i < 6; i++) load_entry({4'd0, 8'h00, 8'(8'h11 + i)});
        pulse_start();
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (done !== 1'b1) $display("FAIL ovf_done_timeout got %b exp 1", done); else passed++;
        checks++; if (bus.cap_ovf !== 1'b1) $display("FAIL ovf_flag got %b exp 1", bus.cap_ovf); else passed++;
        for (int i = 0; i < 4; i++) begin
            exp_d = {12'(i), 8'(8'h11 + i)};
            checks++; if (bus.cap_valid !== 1'b1) $display("FAIL ovf_valid%0d got %b exp 1", i, bus.cap_valid); else passed++;
            checks++; if (bus.cap_data !== exp_d) $display("FAIL ovf_data%0d got %h exp %h", i, bus.cap_data, exp_d); else passed++;
            bus.cap_ready = 1'b1;
            tick();
            bus.cap_ready = 1'b0;
        end
        checks++; if (bus.cap_valid !== 1'b0) $display("FAIL ovf_empty got %b exp 0", bus.cap_valid); else passed++;
        checks++; if (bus.cap_ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", bus.cap_ovf); else passed++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        checks++; if (bus.cap_ovf !== 1'b0) $display("FAIL ovf_abort_clear got %b exp 0", bus.cap_ovf); else passed++;
    endtask

    task automatic test_depth();
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus.ld_ready !== 1'b1) $display("FAIL depth_ready%0d got %b exp 1", i, bus.ld_ready); else passed++;
            load_entry({4'd0, 8'h00, 8'(i)});
        end
        checks++; if (bus.ld_ready !== 1'b0) $display("FAIL depth_full_ready got %b exp 0", bus.ld_ready); else passed++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) $display("FAIL depth_abort_ready got %b exp 1", bus.ld_ready); else passed++;
    endtask

    initial begin
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.cap_ready = 1'b0;
        test_reset();
        test_start_empty();
        test_sequence();
        test_abort();
        test_overflow();
        test_depth();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d of %0d checks", passed, checks);
        $fatal(1);
    end
endmodule
